// File: rtl/prio_enc_queue_pkg.sv
// Shared types and helpers for prio_enc_queue: index-width helper and a
// rotating highest-set-bit search used by prio_find.
package prio_enc_pkg;
  localparam int N_DEFAULT = 8;
  localparam int N_MAX     = 64;

  typedef struct packed {
    logic [5:0] idx;
    logic       found;
  } find_t;

  function automatic int idx_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Search vec[start], vec[start-1], ... wrapping from 0 to n-1; first hit wins.
  function automatic find_t find_highest(logic [N_MAX-1:0] vec, int start, int n);
    find_t r;
    int    p;
    r = '0;
    for (int k = 0; k < N_MAX; k++) begin
      if (k < n) begin
        p = start - k;
        if (p < 0) p = p + n;
        if (!r.found && vec[p]) begin
          r.found = 1'b1;
          r.idx   = 6'(p);
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/prio_enc_queue_if.sv
// Output slot handshake of prio_enc_queue: granted index with valid/ready.
interface prio_enc_queue_if import prio_enc_pkg::*; #(
  parameter int N = N_DEFAULT
);
  localparam int W = idx_w(N);
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/prio_enc_queue_find.sv
// prio_find: combinational N-bit highest-set-bit finder, searching downward
// from a rotating start index.
module prio_find import prio_enc_pkg::*; #(
  parameter int N = N_DEFAULT,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found,
  output logic [N-1:0] onehot
);
  find_t r;

  always_comb begin
    r      = find_highest(N_MAX'(vec), int'(start), N);
    idx    = W'(r.idx);
    found  = r.found;
    onehot = r.found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/prio_enc_queue.sv
// Registered priority encoder with request memory and a valid/ready output slot.
// Define PRIO_ENC_RR_EN for round-robin search instead of fixed priority.
module prio_enc_queue import prio_enc_pkg::*; #(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             clr,
  prio_enc_queue_if.master q,
  output logic [N-1:0]     pending,
  output logic             overflow
);
  localparam int W = idx_w(N);

  logic [W-1:0] idx_q, start, fidx;
  logic         valid_q, found, slot_free;
  logic [N-1:0] hit_oh, sel_oh;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] last_idx;
  // last_idx is searched last: start one below it, wrapping to N-1.
  assign start = (last_idx == '0) ? W'(N - 1) : last_idx - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last_idx <= W'(N - 1);
    else if (!clr && slot_free && found) last_idx <= fidx;
  end
`else
  assign start = W'(N - 1);
`endif

  prio_find #(.N(N), .W(W)) u_find (
    .vec    (pending),
    .start  (start),
    .idx    (fidx),
    .found  (found),
    .onehot (hit_oh)
  );

  assign slot_free = !valid_q || q.out_ready;
  assign sel_oh    = slot_free ? hit_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      pending  <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A request merging into a still-set pending bit is lost; the bit
      // moving into the slot this edge is free to re-arm.
      pending  <= (pending & ~sel_oh) | req_in;
      overflow <= |(req_in & pending & ~sel_oh);
      if (slot_free) begin
        valid_q <= found;
        if (found) idx_q <= fidx;
      end
    end
  end

  assign q.out_idx   = idx_q;
  assign q.out_valid = valid_q;
endmodule
